// File: rtl/internal_bus_latched.sv
// Resolves INPUTS one-hot-selected WIDTH-bit sources onto a single bus, with a
// phase-enabled latch of the bus and registered driver/contention status.
module internal_bus_latched #(
  parameter int                 INPUTS          = 2,
  parameter int                 WIDTH           = 8,
  parameter int                 IDLE_MODE       = 1,
  parameter int                 CONTENTION_MODE = 0,
  parameter logic [WIDTH-1:0]   RESET_VALUE     = '1,
  parameter int                 CNT_WIDTH       = 8,
  localparam int                IDXW            = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [INPUTS-1:0]         busSelect,
  input  logic [WIDTH*INPUTS-1:0]   busInputs,
  input  logic                      clearStatus,
  output logic [WIDTH-1:0]          busOutput,
  output logic [WIDTH-1:0]          busLatched,
  output logic                      busDriven,
  output logic [IDXW-1:0]           lastDriver,
  output logic                      contention,
  output logic [CNT_WIDTH-1:0]      contentionCount
);

  logic [WIDTH-1:0] and_acc;
  logic [WIDTH-1:0] or_acc;
  logic [WIDTH-1:0] low_val;
  logic [IDXW-1:0]  low_idx;
  logic             any_sel;
  logic             multi_sel;
  logic [WIDTH-1:0] idle_val;
  logic             hit;

  // Only selected sources enter the accumulators, so unselected X never leaks.
  always_comb begin
    and_acc   = '1;
    or_acc    = '0;
    low_val   = '0;
    low_idx   = '0;
    any_sel   = 1'b0;
    multi_sel = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (busSelect[i]) begin
        and_acc = and_acc & busInputs[WIDTH*i +: WIDTH];
        or_acc  = or_acc  | busInputs[WIDTH*i +: WIDTH];
        if (any_sel) begin
          multi_sel = 1'b1;
        end else begin
          low_val = busInputs[WIDTH*i +: WIDTH];
          low_idx = IDXW'(i);
        end
        any_sel = 1'b1;
      end
    end
  end

  always_comb begin
    case (IDLE_MODE)
      0:       idle_val = busLatched;
      2:       idle_val = '0;
      default: idle_val = '1;
    endcase
  end

  always_comb begin
    busOutput = low_val;
    if (!any_sel) begin
      busOutput = idle_val;
    end else if (multi_sel) begin
      case (CONTENTION_MODE)
        1:       busOutput = or_acc;
        2:       busOutput = low_val;
        default: busOutput = and_acc;
      endcase
    end
  end

  assign hit = en & multi_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      busLatched      <= RESET_VALUE;
      busDriven       <= 1'b0;
      lastDriver      <= '0;
      contention      <= 1'b0;
      contentionCount <= '0;
    end else begin
      if (en) begin
        busLatched <= busOutput;
        busDriven  <= any_sel;
        if (any_sel) lastDriver <= low_idx;
      end
      // A new hit outranks a simultaneous clear: flag stays set, count restarts at 1.
      contention <= hit | (contention & ~clearStatus);
      if (clearStatus) begin
        contentionCount <= hit ? CNT_WIDTH'(1) : '0;
      end else if (hit && (contentionCount != '1)) begin
        contentionCount <= contentionCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_internal_bus_latched.sv
// Checks three parameterisations of internal_bus_latched against a queue-based
// reference model, with directed steps followed by random traffic.
module tb_internal_bus_latched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [3:0]  sel;
  logic [31:0] bus_in;

  logic [7:0] out0, lat0; logic drv0; logic [1:0] ld0; logic c0; logic [1:0] cc0;
  logic [7:0] out1, lat1; logic drv1; logic [1:0] ld1; logic c1; logic [7:0] cc1;
  logic [7:0] out2, lat2; logic drv2; logic [1:0] ld2; logic c2; logic [2:0] cc2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  internal_bus_latched #(.INPUTS(4), .WIDTH(8), .IDLE_MODE(1), .CONTENTION_MODE(0),
                         .RESET_VALUE(8'hFF), .CNT_WIDTH(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .busSelect(sel), .busInputs(bus_in),
    .clearStatus(clr), .busOutput(out0), .busLatched(lat0), .busDriven(drv0),
    .lastDriver(ld0), .contention(c0), .contentionCount(cc0));

  internal_bus_latched #(.INPUTS(4), .WIDTH(8), .IDLE_MODE(2), .CONTENTION_MODE(1),
                         .RESET_VALUE(8'hFF), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .busSelect(sel), .busInputs(bus_in),
    .clearStatus(clr), .busOutput(out1), .busLatched(lat1), .busDriven(drv1),
    .lastDriver(ld1), .contention(c1), .contentionCount(cc1));

  internal_bus_latched #(.INPUTS(4), .WIDTH(8), .IDLE_MODE(0), .CONTENTION_MODE(2),
                         .RESET_VALUE(8'hFF), .CNT_WIDTH(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .busSelect(sel), .busInputs(bus_in),
    .clearStatus(clr), .busOutput(out2), .busLatched(lat2), .busDriven(drv2),
    .lastDriver(ld2), .contention(c2), .contentionCount(cc2));

  // Reference model state, one entry per instance.
  int         idle_m [3] = '{1, 2, 0};
  int         cmode  [3] = '{0, 1, 2};
  int         cmax   [3] = '{3, 255, 7};
  logic [7:0] m_lat  [3];
  bit         m_drv  [3];
  int         m_last [3];
  bit         m_cont [3];
  int         m_cnt  [3];

  function automatic logic [7:0] model_out(int k);
    logic [7:0] vals[$];
    logic [7:0] r;
    for (int i = 0; i < 4; i++)
      if (sel[i]) vals.push_back(bus_in[8*i +: 8]);
    if (vals.size() == 0) begin
      if (idle_m[k] == 0)      r = m_lat[k];
      else if (idle_m[k] == 1) r = 8'hFF;
      else                     r = 8'h00;
    end else if (vals.size() == 1) begin
      r = vals[0];
    end else if (cmode[k] == 0) begin
      r = 8'hFF;
      foreach (vals[j]) r = r & vals[j];
    end else if (cmode[k] == 1) begin
      r = 8'h00;
      foreach (vals[j]) r = r | vals[j];
    end else begin
      r = vals[0];
    end
    return r;
  endfunction

  task automatic model_edge();
    int n;
    int low;
    bit hit;
    logic [7:0] o;
    n   = $countones(sel);
    low = -1;
    for (int i = 3; i >= 0; i--) if (sel[i]) low = i;
    for (int k = 0; k < 3; k++) begin
      o = model_out(k);
      if (rst) begin
        m_lat[k] = 8'hFF; m_drv[k] = 0; m_last[k] = 0; m_cont[k] = 0; m_cnt[k] = 0;
      end else begin
        if (en) begin
          m_lat[k] = o;
          m_drv[k] = (n > 0);
          if (n > 0) m_last[k] = low;
        end
        hit = en && (n > 1);
        m_cont[k] = hit || (m_cont[k] && !clr);
        if (clr)      m_cnt[k] = hit ? 1 : 0;
        else if (hit) m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : cmax[k];
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    chk({ph, ".out0"}, out0, model_out(0));
    chk({ph, ".lat0"}, lat0, m_lat[0]);
    chk({ph, ".drv0"}, drv0, m_drv[0]);
    chk({ph, ".ld0"},  ld0,  m_last[0]);
    chk({ph, ".c0"},   c0,   m_cont[0]);
    chk({ph, ".cc0"},  cc0,  m_cnt[0]);
    chk({ph, ".out1"}, out1, model_out(1));
    chk({ph, ".lat1"}, lat1, m_lat[1]);
    chk({ph, ".drv1"}, drv1, m_drv[1]);
    chk({ph, ".ld1"},  ld1,  m_last[1]);
    chk({ph, ".c1"},   c1,   m_cont[1]);
    chk({ph, ".cc1"},  cc1,  m_cnt[1]);
    chk({ph, ".out2"}, out2, model_out(2));
    chk({ph, ".lat2"}, lat2, m_lat[2]);
    chk({ph, ".drv2"}, drv2, m_drv[2]);
    chk({ph, ".ld2"},  ld2,  m_last[2]);
    chk({ph, ".c2"},   c2,   m_cont[2]);
    chk({ph, ".cc2"},  cc2,  m_cnt[2]);
  endtask

  task automatic apply(logic [3:0] s, logic [31:0] b, logic e, logic c, logic r);
    sel = s; bus_in = b; en = e; clr = c; rst = r;
    #1;
    check_all("comb");
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all("reg");
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    sel = 4'b0000; bus_in = 32'h0; en = 1'b0; clr = 1'b0; rst = 1'b1;
    tick();
    tick();

    // Reset / idle values
    apply(4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_lat0", lat0, 8'hFF);
    chk("rst_out0", out0, 8'hFF);
    chk("rst_out1", out1, 8'h00);
    chk("rst_out2", out2, 8'hFF);
    chk("rst_drv0", drv0, 1'b0);
    chk("rst_cc0",  cc0,  2'd0);

    // Single driver, then hold with en low
    apply(4'b0100, 32'h44332211, 1'b1, 1'b0, 1'b0);
    chk("single_out0", out0, 8'h33);
    tick();
    chk("single_lat0", lat0, 8'h33);
    chk("single_drv0", drv0, 1'b1);
    chk("single_ld0",  ld0,  2'd2);
    apply(4'b0001, 32'h44332211, 1'b0, 1'b0, 1'b0);
    tick();
    chk("hold_lat0", lat0, 8'h33);

    // Contention resolution in the three modes
    apply(4'b0011, 32'h44333CF0, 1'b1, 1'b0, 1'b0);
    chk("and_out0", out0, 8'h30);
    chk("or_out1",  out1, 8'hFC);
    chk("low_out2", out2, 8'hF0);
    tick();
    chk("cont_c0",  c0,  1'b1);
    chk("cont_cc0", cc0, 2'd1);
    chk("cont_ld0", ld0, 2'd0);

    // Saturation and clear behaviour on the 2-bit counter
    apply(4'b0001, 32'h44333CF0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("clr_cc0", cc0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      apply(4'b0011, 32'h44333CF0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("sat_cc0", cc0, sat_exp[i]);
    end
    apply(4'b0001, 32'h44333CF0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("clr2_cc0", cc0, 2'd0);
    chk("clr2_c0",  c0,  1'b0);
    apply(4'b0011, 32'h44333CF0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("setclr_cc0", cc0, 2'd1);
    chk("setclr_c0",  c0,  1'b1);
    apply(4'b0011, 32'h44333CF0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("dis_cc0", cc0, 2'd1);

    // Hold idle mode keeps the last latched value
    apply(4'b0001, 32'h0000005A, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, 32'h0000005A, 1'b1, 1'b0, 1'b0);
      chk("idle_out2", out2, 8'h5A);
      tick();
      chk("idle_lat2", lat2, 8'h5A);
      chk("idle_drv2", drv2, 1'b0);
    end

    // Reset in the middle of contention
    apply(4'b0011, 32'h44332211, 1'b1, 1'b1, 1'b0);
    tick();
    apply(4'b0011, 32'h44332211, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_cc0", cc0, 2'd2);
    apply(4'b0010, 32'h44332211, 1'b1, 1'b0, 1'b1);
    tick();
    chk("mid_rst_cc0",  cc0,  2'd0);
    chk("mid_rst_c0",   c0,   1'b0);
    chk("mid_rst_lat0", lat0, 8'hFF);
    chk("mid_rst_ld0",  ld0,  2'd0);
    apply(4'b0010, 32'h44332211, 1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_lat0", lat0, 8'h22);
    chk("post_rst_ld0",  ld0,  2'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply(4'($urandom), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/internal_bus_latched.md
Name: internal_bus_latched

Overview:
Parametrised successor to the one-hot-select internal data bus of the 8227 datapath. It resolves N WIDTH-bit sources onto one bus with a defined idle value and a defined contention rule. It also holds a phase-enabled latch of the bus, as the NMOS bus does between phases. Registered status reports contention, the last driver and whether the bus was driven, and feeds microcode debug and the verification monitors.

Parameters:
INPUTS, 2, number of bus sources (>=1)
WIDTH, 8, bits per source
IDLE_MODE, 1, value when no select is active: 0 = hold busLatched, 1 = all-ones precharge, 2 = all-zeros
CONTENTION_MODE, 0, resolution when >1 select is active: 0 = bitwise AND (wired-AND), 1 = bitwise OR, 2 = lowest-index source wins
RESET_VALUE, all-ones, busLatched value after reset (WIDTH bits)
CNT_WIDTH, 8, width of contention counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  phase enable; latch/status update only when high
busSelect  in  INPUTS  one-hot source select (bit i selects source i)
busInputs  in  WIDTH*INPUTS  source i at bits [WIDTH*(i+1)-1 : WIDTH*i]
clearStatus  in  1  clears contention flag and counter
busOutput  out  WIDTH  combinational resolved bus value
busLatched  out  WIDTH  registered bus value
busDriven  out  1  registered: >=1 select active at last enabled edge
lastDriver  out  IDXW  registered index of last driving source; IDXW = max(1, clog2(INPUTS))
contention  out  1  sticky: >1 select seen on an enabled edge
contentionCount  out  CNT_WIDTH  saturating count of enabled contention cycles

Behaviour:
- Combinational resolve, zero latency to busOutput:
  - popcount(busSelect) = 0: busOutput = idle value (busLatched / all-ones / all-zeros per IDLE_MODE).
  - popcount = 1: busOutput = the selected source.
  - popcount > 1: busOutput = AND or OR over all selected sources, or the lowest-index selected source, per CONTENTION_MODE. Unselected sources never contribute.
- The select is decoded over all INPUTS bits. Selecting by any index wider than INPUTS is forbidden.
- Rising clk with rst = 1 (rst has priority over en and clearStatus):
  - busLatched = RESET_VALUE; busDriven = 0; lastDriver = 0; contention = 0; contentionCount = 0.
  - Reset in mid-operation discards all history immediately.
- Rising clk with en = 1:
  - busLatched <= busOutput.
  - busDriven <= (popcount >= 1).
  - lastDriver <= lowest set index of busSelect, if any is set; otherwise it holds.
- Rising clk with en = 0: busLatched, busDriven and lastDriver hold. With IDLE_MODE = 0, busOutput still follows the held busLatched.
- Contention status, evaluated at rising clk when not in reset:
  - hit = en & (popcount > 1).
  - contention <= hit | (contention & ~clearStatus). Set wins over a simultaneous clear.
  - contentionCount:
    - clearStatus & hit: 1.
    - clearStatus alone: 0.
    - hit alone: count+1, saturating at all-ones (no wrap).
    - otherwise: hold.
  - clearStatus is accepted regardless of en.
- IDLE_MODE = 0 with no select: busLatched reloads its own value, a stable hold with no loop hazard since the path goes through the register.
- INPUTS = 1: lastDriver is 1 bit, constant 0; contention can never assert.
- Every output is registered except busOutput. There is no X propagation from unselected sources.

Test Plan:
- Reset/idle: INPUTS=4, WIDTH=8, IDLE_MODE=1. Assert rst 2 cycles, then select=0 -> busLatched=0xFF, busOutput=0xFF, busDriven=0, contention=0, contentionCount=0.
- Single driver: inputs {0x44,0x33,0x22,0x11}, select=4'b0100, en=1 -> busOutput=0x33 same cycle; next edge busLatched=0x33, busDriven=1, lastDriver=2. Drop en, change select to 0001 -> busLatched stays 0x33.
- Contention modes: select=4'b0011, inputs[0]=0xF0, inputs[1]=0x3C -> busOutput 0x30 (mode 0), 0xFC (mode 1), 0xF0 (mode 2). One enabled edge -> contention=1, count=1, lastDriver=0.
- Counter saturation/clear: CNT_WIDTH=2, hold contention 5 enabled cycles -> count 1,2,3,3,3. Assert clearStatus with select=0001 -> count=0, contention=0. Assert clearStatus with select=0011 -> count=1, contention=1. Contention with en=0 -> no change.
- Hold mode: IDLE_MODE=0, drive 0x5A one enabled cycle, then select=0 for 3 enabled cycles -> busOutput=busLatched=0x5A throughout, busDriven=0.
- Reset mid-operation: during contention with count=2, assert rst alongside en=1 and select=0010 -> next edge all status 0, busLatched=RESET_VALUE. Next enabled edge latches source 1.
